// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction-fetch stage.
//   XLEN_DEF      - default instruction / PC width
//   NOP_INST      - word returned for a faulting fetch
//   fetch_entry_t - output queue entry {inst, pc, fault} at the default width
//   entry_width() - packed width of one queue entry for a given XLEN
package fetch_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [XLEN_DEF-1:0] NOP_INST = '0;

    typedef struct packed {
        logic [XLEN_DEF-1:0] inst;
        logic [XLEN_DEF-1:0] pc;
        logic                fault;
    } fetch_entry_t;

    function automatic int entry_width(input int xlen);
        return 2 * xlen + 1;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: program-load, redirect and decode-side handshake bundle.
//   imem_we/imem_waddr/imem_wdata - instruction memory write port
//   redirect_valid/redirect_pc    - restart fetch at a new word address
//   out_valid/out_ready           - valid/ready handshake towards decode
//   out_inst/out_pc/out_pc_next   - delivered instruction and its PCs
//   out_fault                     - delivered PC lies outside the memory
// master: the fetch unit.  slave: the decode / loader side.
interface fetch_unit_if #(
    parameter int XLEN = fetch_pkg::XLEN_DEF,
    parameter int AW   = 5
);
    logic            imem_we;
    logic [AW-1:0]   imem_waddr;
    logic [XLEN-1:0] imem_wdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_inst;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_pc_next;
    logic            out_fault;

    modport master (
        input  imem_we, imem_waddr, imem_wdata, redirect_valid, redirect_pc, out_ready,
        output out_valid, out_inst, out_pc, out_pc_next, out_fault
    );

    modport slave (
        output imem_we, imem_waddr, imem_wdata, redirect_valid, redirect_pc, out_ready,
        input  out_valid, out_inst, out_pc, out_pc_next, out_fault
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO holding fetched entries until decode takes them.
//   clk, rst  - clock, synchronous active-high reset
//   clear_i   - drop every entry (redirect)
//   push_i    - write din_i at the tail
//   pop_i     - retire the head entry
//   din_i     - entry to push
//   head_o    - current head entry
//   count_o   - number of valid entries
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int W     = 65
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               din_i,
    output logic [W-1:0]               head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [CW-1:0] count_q;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wr_q <= ptr_inc(wr_q);
            if (pop_i)  rd_q <= ptr_inc(rd_q);
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    // Storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= din_i;
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = count_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: clocked instruction-fetch stage.
// Holds the fetch PC, reads a word-addressed instruction memory with one
// cycle of latency, buffers results in fetch_queue and hands them to decode
// over a valid/ready handshake. A redirect flushes everything in flight.
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous active-high reset
//   bus  - fetch_unit_if.master (program load, redirect, decode handshake)
// Build option: FETCH_FAULT_EN - PCs >= IMEM_DEPTH return NOP with
//   out_fault=1 and halt fetch until a redirect; when undefined the memory
//   index uses the low PC bits and fetch wraps.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN        = XLEN_DEF,
    parameter int              IMEM_DEPTH  = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              QUEUE_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    localparam int AW = $clog2(IMEM_DEPTH);
    localparam int EW = entry_width(XLEN);
    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam int OW = CW + 1;

    logic [XLEN-1:0] imem [IMEM_DEPTH];

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            rvalid_q, rvalid_d;
    logic            halted_q, halted_d;
    logic [XLEN-1:0] rdata_q;
    logic [XLEN-1:0] rpc_q;
    logic            rfault_q;

    logic [CW-1:0]   q_count;
    logic [EW-1:0]   q_head;
    logic            out_valid_w, pop, push, issue, pc_fault;
    logic [OW-1:0]   occ;

    always_ff @(posedge clk) begin
        if (bus.imem_we) imem[bus.imem_waddr] <= bus.imem_wdata;
    end

`ifdef FETCH_FAULT_EN
    assign pc_fault = (fetch_pc_q >= XLEN'(IMEM_DEPTH));
`else
    assign pc_fault = 1'b0;
`endif

    assign out_valid_w = (q_count != '0);
    assign pop         = out_valid_w & bus.out_ready;
    assign push        = rvalid_q & ~bus.redirect_valid;

    // Credit: entries that will occupy the queue after this edge. Issuing
    // only while below depth guarantees the queue never overflows.
    assign occ   = OW'(q_count) + OW'(rvalid_q) - OW'(pop);
    assign issue = (occ < OW'(QUEUE_DEPTH)) && !halted_q && !bus.redirect_valid;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rvalid_d   = rvalid_q;
        halted_d   = halted_q;
        if (bus.redirect_valid) begin
            fetch_pc_d = bus.redirect_pc;
            rvalid_d   = 1'b0;
            halted_d   = 1'b0;
        end else begin
            rvalid_d = issue;
            if (issue) begin
                fetch_pc_d = fetch_pc_q + 1'b1;
                if (pc_fault) halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            rvalid_q   <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rvalid_q   <= rvalid_d;
            halted_q   <= halted_d;
        end
    end

    // Read stage: nonblocking read returns the old word on a same-cycle write.
    always_ff @(posedge clk) begin
        if (issue) begin
            rdata_q  <= pc_fault ? XLEN'(NOP_INST) : imem[fetch_pc_q[AW-1:0]];
            rpc_q    <= fetch_pc_q;
            rfault_q <= pc_fault;
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .W     (EW)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .clear_i (bus.redirect_valid),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   ({rdata_q, rpc_q, rfault_q}),
        .head_o  (q_head),
        .count_o (q_count)
    );

    // Outputs read as zero whenever nothing valid is presented, so stale
    // queue storage never shows on the bus after reset or a flush.
    assign bus.out_valid   = out_valid_w;
    assign bus.out_inst    = out_valid_w ? q_head[EW-1 -: XLEN] : '0;
    assign bus.out_pc      = out_valid_w ? q_head[XLEN:1] : '0;
    assign bus.out_pc_next = out_valid_w ? q_head[XLEN:1] + 1'b1 : '0;
    assign bus.out_fault   = out_valid_w & q_head[0];
endmodule
